// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        HOLD
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   BYTE_W   = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the raw SCL/SDA pads and derives one-clock edge, START and STOP pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl;
    logic                   scl_prev;
    logic                   sda_prev;

    // Flops reset to the idle-bus level so release from reset produces no false edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_pipe[SYNC_STAGES-1];
            sda_prev <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_pipe[SYNC_STAGES-1];
    assign sda       = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_slave_regctl.sv
// I2C slave fronting a NUM_REGS x 8 register file with a pointer, auto-increment and
// write-pointer-then-read access; out-of-range bytes are NACKed.
module i2c_slave_regctl
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h49,
    parameter int         NUM_REGS    = 16,
    parameter bit         WRAP        = 1'b1,
    parameter int         SYNC_STAGES = 2,
    localparam int        REG_AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              txn_done,
    output logic              err_nack
);

    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    i2c_state_t        state;
    logic [2:0]        bit_cnt;
    logic              byte_done;
    logic [BYTE_W-1:0] shreg;
    logic              rw;
    logic              mack;
    logic              addr_acked;
    logic              rd_req;
    logic              rd_wait;
    logic [REG_AW-1:0] ptr;
    logic              ovf;
    logic [REG_AW-1:0] ptr_next;
    logic              ovf_next;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Pointer advance: wrap to 0, or park on the last register and flag overflow.
    always_comb begin
        ptr_next = ptr + REG_AW'(1);
        ovf_next = ovf;
        if (32'(ptr) == 32'(NUM_REGS - 1)) begin
            if (WRAP) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr;
                ovf_next = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            shreg      <= '0;
            rw         <= 1'b0;
            mack       <= 1'b0;
            addr_acked <= 1'b0;
            rd_req     <= 1'b0;
            rd_wait    <= 1'b0;
            ptr        <= '0;
            ovf        <= 1'b0;
            sda_oe     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            txn_done   <= 1'b0;
            err_nack   <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            txn_done <= 1'b0;
            err_nack <= 1'b0;
            rd_req   <= 1'b0;
            rd_wait  <= rd_req;
            reg_addr <= ptr;
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= '0;
                byte_done  <= 1'b0;
                sda_oe     <= 1'b0;
                addr_acked <= 1'b0;
            end else if (stop_det) begin
                txn_done   <= (state != IDLE) && addr_acked;
                state      <= IDLE;
                sda_oe     <= 1'b0;
                addr_acked <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WRITE: begin
                        if (scl_rise && !byte_done) begin
                            shreg <= {shreg[BYTE_W-2:0], sda};
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                            else                 bit_cnt   <= bit_cnt + 3'd1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == DEV_ADDR) begin
                                    state      <= ADDR_ACK;
                                    sda_oe     <= 1'b1;
                                    addr_acked <= 1'b1;
                                    rw         <= shreg[0];
                                    reg_re     <= shreg[0] & ~ovf;
                                    rd_req     <= shreg[0];
                                end else begin
                                    state <= HOLD;
                                end
                            end else if (state == PTR) begin
                                if ({24'd0, shreg} < 32'(NUM_REGS)) begin
                                    state  <= PTR_ACK;
                                    sda_oe <= 1'b1;
                                    ptr    <= REG_AW'(shreg);
                                    ovf    <= 1'b0;
                                end else begin
                                    state    <= HOLD;
                                    sda_oe   <= 1'b0;
                                    err_nack <= 1'b1;
                                end
                            end else begin
                                state <= WRITE_ACK;
                                if (!ovf) begin
                                    reg_we    <= 1'b1;
                                    reg_wdata <= shreg;
                                    reg_addr  <= ptr;
                                    sda_oe    <= 1'b1;
                                    ptr       <= ptr_next;
                                    ovf       <= ovf_next;
                                end else begin
                                    sda_oe   <= 1'b0;
                                    err_nack <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state   <= READ;
                                sda_oe  <= ~shreg[7];
                                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                                bit_cnt <= '0;
                            end else begin
                                state  <= PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    PTR_ACK, WRITE_ACK: begin
                        if (scl_fall) begin
                            state  <= WRITE;
                            sda_oe <= 1'b0;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                state   <= READ_ACK;
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                sda_oe  <= ~shreg[7];
                                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    READ_ACK: begin
                        // The master's ACK triggers the next register fetch during SCL high.
                        if (scl_rise) begin
                            mack <= sda;
                            if (sda == I2C_ACK) begin
                                ptr      <= ptr_next;
                                ovf      <= ovf_next;
                                reg_addr <= ptr_next;
                                reg_re   <= ~ovf_next;
                                rd_req   <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (mack == I2C_NACK) begin
                                state <= HOLD;
                            end else begin
                                state   <= READ;
                                sda_oe  <= ~shreg[7];
                                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                                bit_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
                // Read data arrives one clock after the strobe; overflowed reads return all ones.
                if (rd_wait) shreg <= ovf ? 8'hFF : reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regctl.sv
// Directed bench: a wrapping slave at 0x49 and a saturating slave at 0x4A share one I2C bus and register model.
module tb_i2c_slave_regctl;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_m   = 1'b1;
    logic       sda_bus;
    logic       sda_oe_w, sda_oe_s;
    logic [3:0] reg_addr_w, reg_addr_s;
    logic [7:0] reg_wdata_w, reg_wdata_s;
    logic       reg_we_w, reg_we_s, reg_re_w, reg_re_s;
    logic       busy_w, busy_s, txn_done_w, txn_done_s, err_nack_w, err_nack_s;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] regs [16];
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata;

    int checks = 0;
    int errors = 0;
    int txn_w_cnt = 0, txn_s_cnt = 0, nack_w_cnt = 0, nack_s_cnt = 0, oe_cnt = 0;
    logic [31:0] wr_q[$];
    logic [31:0] rd_q[$];

    always #5 clock = ~clock;

    assign sda_bus   = sda_m & ~sda_oe_w & ~sda_oe_s;
    assign bus_addr  = (reg_we_s || reg_re_s) ? reg_addr_s : reg_addr_w;
    assign bus_wdata = reg_we_s ? reg_wdata_s : reg_wdata_w;

    i2c_slave_regctl #(.DEV_ADDR(7'h49), .NUM_REGS(16), .WRAP(1'b1), .SYNC_STAGES(2)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe_w),
        .reg_addr(reg_addr_w), .reg_wdata(reg_wdata_w), .reg_we(reg_we_w), .reg_re(reg_re_w),
        .reg_rdata(reg_rdata), .busy(busy_w), .txn_done(txn_done_w), .err_nack(err_nack_w)
    );

    i2c_slave_regctl #(.DEV_ADDR(7'h4A), .NUM_REGS(16), .WRAP(1'b0), .SYNC_STAGES(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe_s),
        .reg_addr(reg_addr_s), .reg_wdata(reg_wdata_s), .reg_we(reg_we_s), .reg_re(reg_re_s),
        .reg_rdata(reg_rdata), .busy(busy_s), .txn_done(txn_done_s), .err_nack(err_nack_s)
    );

    // Register file model with a one-clock read latency.
    always @(posedge clock) begin
        if (reg_we_w || reg_we_s) regs[bus_addr] <= bus_wdata;
        if (reg_re_w || reg_re_s) reg_rdata <= regs[bus_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Strobe scoreboard; an unexpected strobe is compared against an unreachable sentinel.
    always @(negedge clock) begin
        logic [31:0] exp_v;
        if (reg_we_w || reg_we_s) begin
            exp_v = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hDEAD_BEEF;
            check_output("reg_we", {20'd0, bus_addr, bus_wdata}, exp_v);
        end
        if (reg_re_w || reg_re_s) begin
            exp_v = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            check_output("reg_re", {28'd0, bus_addr}, exp_v);
        end
        if (txn_done_w) txn_w_cnt++;
        if (txn_done_s) txn_s_cnt++;
        if (err_nack_w) nack_w_cnt++;
        if (err_nack_s) nack_s_cnt++;
        if (sda_oe_w || sda_oe_s) oe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(4);
        scl   = 1'b1; tick(4);
        sda_m = 1'b0; tick(4);
        scl   = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(4);
        scl   = 1'b1; tick(4);
        sda_m = 1'b1; tick(4);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(4);
        scl   = 1'b1; tick(8);
        scl   = 1'b0; tick(4);
    endtask

    // Master writes a byte and checks the slave's ACK bit (0 = ACK, 1 = NACK).
    task automatic apply_stimulus(input logic [7:0] data, input logic exp_ack_bit, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        sda_m = 1'b1; tick(4);
        scl   = 1'b1; tick(4);
        ack   = sda_bus; tick(4);
        scl   = 1'b0; tick(4);
        check_output(tag, {31'd0, ack}, {31'd0, exp_ack_bit});
    endtask

    task automatic read_byte(input logic [7:0] exp_data, input logic master_ack_bit, input string tag);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            sda_m  = 1'b1; tick(4);
            scl    = 1'b1; tick(4);
            got[i] = sda_bus; tick(4);
            scl    = 1'b0; tick(4);
        end
        sda_m = master_ack_bit; tick(4);
        scl   = 1'b1; tick(8);
        scl   = 1'b0; tick(4);
        sda_m = 1'b1;
        check_output(tag, {24'd0, got}, {24'd0, exp_data});
    endtask

    initial begin
        int t0, n0, s0, m0, o0;

        tick(3);
        check_output("rst_sda_oe", {31'd0, sda_oe_w}, 32'd0);
        check_output("rst_busy", {31'd0, busy_w}, 32'd0);
        check_output("rst_strobes", {28'd0, reg_we_w, reg_re_w, txn_done_w, err_nack_w}, 32'd0);
        check_output("rst_addr_wdata", {20'd0, reg_addr_w, reg_wdata_w}, 32'd0);
        reset_n = 1'b1;
        tick(4);

        $display("[TB] test 1: pointer write then two data bytes");
        t0 = txn_w_cnt;
        wr_q.push_back({20'd0, 4'h3, 8'hA5});
        wr_q.push_back({20'd0, 4'h4, 8'h5A});
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t1_addr_ack");
        apply_stimulus(8'h03, 1'b0, "t1_ptr_ack");
        check_output("t1_busy", {31'd0, busy_w}, 32'd1);
        apply_stimulus(8'hA5, 1'b0, "t1_d0_ack");
        apply_stimulus(8'h5A, 1'b0, "t1_d1_ack");
        i2c_stop();
        tick(4);
        check_output("t1_txn_done", 32'(txn_w_cnt - t0), 32'd1);
        check_output("t1_idle", {31'd0, busy_w}, 32'd0);
        check_output("t1_wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("[TB] test 2: write E/F then repeated-start read");
        wr_q.push_back({20'd0, 4'hE, 8'h11});
        wr_q.push_back({20'd0, 4'hF, 8'h22});
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t2_addr_ack");
        apply_stimulus(8'h0E, 1'b0, "t2_ptr_ack");
        apply_stimulus(8'h11, 1'b0, "t2_d0_ack");
        apply_stimulus(8'h22, 1'b0, "t2_d1_ack");
        i2c_stop();
        t0 = txn_w_cnt;
        rd_q.push_back(32'hE);
        rd_q.push_back(32'hF);
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t2r_addr_ack");
        apply_stimulus(8'h0E, 1'b0, "t2r_ptr_ack");
        i2c_start();
        apply_stimulus(8'h93, 1'b0, "t2r_raddr_ack");
        read_byte(8'h11, 1'b0, "t2_read_e");
        read_byte(8'h22, 1'b1, "t2_read_f");
        i2c_stop();
        tick(4);
        check_output("t2_txn_done", 32'(txn_w_cnt - t0), 32'd1);
        check_output("t2_rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("[TB] test 3: pointer boundary, wrap and saturate");
        wr_q.push_back({20'd0, 4'hF, 8'h01});
        wr_q.push_back({20'd0, 4'h0, 8'h02});
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t3w_addr_ack");
        apply_stimulus(8'h0F, 1'b0, "t3w_ptr_ack");
        apply_stimulus(8'h01, 1'b0, "t3w_d0_ack");
        apply_stimulus(8'h02, 1'b0, "t3w_d1_ack");
        i2c_stop();
        check_output("t3w_wr_q_empty", 32'(wr_q.size()), 32'd0);
        n0 = nack_s_cnt;
        s0 = txn_s_cnt;
        wr_q.push_back({20'd0, 4'hF, 8'h01});
        i2c_start();
        apply_stimulus(8'h94, 1'b0, "t3s_addr_ack");
        apply_stimulus(8'h0F, 1'b0, "t3s_ptr_ack");
        apply_stimulus(8'h01, 1'b0, "t3s_d0_ack");
        apply_stimulus(8'h02, 1'b1, "t3s_d1_nack");
        i2c_stop();
        tick(4);
        check_output("t3s_err_nack", 32'(nack_s_cnt - n0), 32'd1);
        check_output("t3s_txn_done", 32'(txn_s_cnt - s0), 32'd1);
        check_output("t3s_wr_q_empty", 32'(wr_q.size()), 32'd0);
        rd_q.push_back(32'hF);
        i2c_start();
        apply_stimulus(8'h94, 1'b0, "t3r_addr_ack");
        apply_stimulus(8'h0F, 1'b0, "t3r_ptr_ack");
        i2c_start();
        apply_stimulus(8'h95, 1'b0, "t3r_raddr_ack");
        read_byte(8'h01, 1'b0, "t3r_read_f");
        read_byte(8'hFF, 1'b1, "t3r_read_ovf");
        i2c_stop();
        tick(4);
        check_output("t3r_rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("[TB] test 4: address mismatch");
        t0 = txn_w_cnt; s0 = txn_s_cnt; o0 = oe_cnt; m0 = nack_w_cnt;
        i2c_start();
        apply_stimulus(8'h90, 1'b1, "t4_addr_nack");
        apply_stimulus(8'h12, 1'b1, "t4_data_ignored");
        check_output("t4_busy", {30'd0, busy_w, busy_s}, 32'd3);
        i2c_stop();
        tick(4);
        check_output("t4_idle", {30'd0, busy_w, busy_s}, 32'd0);
        check_output("t4_oe_never", 32'(oe_cnt - o0), 32'd0);
        check_output("t4_no_txn", 32'(txn_w_cnt - t0 + txn_s_cnt - s0), 32'd0);
        check_output("t4_no_err", 32'(nack_w_cnt - m0), 32'd0);

        $display("[TB] test 5: out-of-range pointer");
        t0 = txn_w_cnt; m0 = nack_w_cnt;
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t5_addr_ack");
        apply_stimulus(8'h20, 1'b1, "t5_ptr_nack");
        check_output("t5_err_nack", 32'(nack_w_cnt - m0), 32'd1);
        apply_stimulus(8'h33, 1'b1, "t5_hold_ignored");
        check_output("t5_hold_busy", {31'd0, busy_w}, 32'd1);
        i2c_stop();
        tick(4);
        check_output("t5_idle", {31'd0, busy_w}, 32'd0);
        check_output("t5_txn_done", 32'(txn_w_cnt - t0), 32'd1);
        check_output("t5_wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("[TB] test 6: reset during a read");
        wr_q.push_back({20'd0, 4'h5, 8'h00});
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t6_waddr_ack");
        apply_stimulus(8'h05, 1'b0, "t6_wptr_ack");
        apply_stimulus(8'h00, 1'b0, "t6_wdata_ack");
        i2c_stop();
        rd_q.push_back(32'h5);
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t6_addr_ack");
        apply_stimulus(8'h05, 1'b0, "t6_ptr_ack");
        i2c_start();
        apply_stimulus(8'h93, 1'b0, "t6_raddr_ack");
        check_output("t6_oe_driving", {31'd0, sda_oe_w}, 32'd1);
        reset_n = 1'b0;
        #2;
        check_output("t6_oe_async_clear", {31'd0, sda_oe_w}, 32'd0);
        check_output("t6_busy_cleared", {31'd0, busy_w}, 32'd0);
        tick(2);
        scl   = 1'b1;
        sda_m = 1'b1;
        tick(4);
        reset_n = 1'b1;
        tick(8);
        t0 = txn_w_cnt;
        i2c_start();
        apply_stimulus(8'h92, 1'b0, "t6_reacquire_ack");
        check_output("t6_busy_again", {31'd0, busy_w}, 32'd1);
        i2c_stop();
        tick(4);
        check_output("t6_txn_done", 32'(txn_w_cnt - t0), 32'd1);
        check_output("t6_queues_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
